// File: rtl/serial_pattern_window_detector.sv
// Serial MSB-first pattern matcher that reports per-slot hits and a hit count
// for each window of 2^WIN_LOG2 enabled samples, plus a saturating running total.
module serial_pattern_window_detector #(
   parameter int               PAT_W       = 4,
   parameter logic [PAT_W-1:0] PAT_DEFAULT = 4'b1101,
   parameter int               WIN_LOG2    = 4,
   parameter int               TOT_W       = 16,
   parameter bit               SPAN        = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    in,
   input  logic [PAT_W-1:0]        pattern,
   input  logic                    overlap,
   input  logic                    clr_total,
   output logic [(2**WIN_LOG2)-1:0] hits,
   output logic [WIN_LOG2:0]       count,
   output logic [TOT_W-1:0]        total,
   output logic                    valid,
   output logic                    busy
);
   localparam int                  WIN       = 2 ** WIN_LOG2;
   localparam int                  CNT_W     = WIN_LOG2 + 1;
   localparam int                  FILL_W    = $clog2(PAT_W + 1);
   localparam logic [WIN_LOG2-1:0] LAST_SLOT = '1;
   localparam logic [TOT_W-1:0]    TOT_MAX   = '1;
   localparam logic [FILL_W-1:0]   FILL_MAX  = FILL_W'(PAT_W);

   logic [WIN_LOG2-1:0] slot_reg;
   logic [PAT_W-2:0]    hist_reg;
   logic [FILL_W-1:0]   fill_reg;
   logic [PAT_W-1:0]    act_pat_reg;
   logic                act_ovl_reg;
   logic [WIN-1:0]      acc_hits_reg;
   logic [CNT_W-1:0]    acc_count_reg;

   logic [PAT_W-1:0]    window_bits;
   logic                match;
   logic                closing;
   logic [WIN-1:0]      slot_hit;
   logic [CNT_W-1:0]    count_next;
   logic [FILL_W-1:0]   fill_next;

   assign window_bits = {hist_reg, in};
   // fill counts how many of the compared bits are genuine samples since the last restart
   assign match       = en && (window_bits == act_pat_reg) &&
                        ((int'(fill_reg) + 1) >= PAT_W);
   assign closing     = en && (slot_reg == LAST_SLOT);
   assign count_next  = acc_count_reg + CNT_W'(match);
   assign busy        = (slot_reg != '0);

   generate
      for (genvar gi = 0; gi < WIN; gi++) begin : g_slot_hit
         assign slot_hit[gi] = match && (slot_reg == WIN_LOG2'(gi));
      end
   endgenerate

   always_comb begin
      fill_next = fill_reg;
      if (match && !act_ovl_reg)
         fill_next = '0;
      else if (fill_reg != FILL_MAX)
         fill_next = fill_reg + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_reg      <= '0;
         hist_reg      <= '0;
         fill_reg      <= '0;
         act_pat_reg   <= PAT_DEFAULT;
         act_ovl_reg   <= 1'b1;
         acc_hits_reg  <= '0;
         acc_count_reg <= '0;
         hits          <= '0;
         count         <= '0;
         total         <= '0;
         valid         <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (en) begin
            slot_reg <= slot_reg + 1'b1;
            hist_reg <= window_bits[PAT_W-2:0];
            fill_reg <= fill_next;
            if (closing) begin
               // the closing slot's own match belongs to the snapshot being published
               hits          <= acc_hits_reg | slot_hit;
               count         <= count_next;
               valid         <= 1'b1;
               acc_hits_reg  <= '0;
               acc_count_reg <= '0;
               act_pat_reg   <= pattern;
               act_ovl_reg   <= overlap;
               if (!SPAN) begin
                  hist_reg <= '0;
                  fill_reg <= '0;
               end
            end else begin
               acc_hits_reg  <= acc_hits_reg | slot_hit;
               acc_count_reg <= count_next;
            end
         end
         if (clr_total)
            total <= '0;
         else if (match && (total != TOT_MAX))
            total <= total + 1'b1;
      end
   end
endmodule

// File: tb/tb_serial_pattern_window_detector.sv
// Bench for serial_pattern_window_detector: three instances (SPAN=0, SPAN=1,
// PAT_W=2/TOT_W=3) checked against a sample-history reference model.
module tb_serial_pattern_window_detector;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        din = 1'b0;
   logic        clr_total = 1'b0;
   logic        overlap = 1'b1;
   logic [3:0]  pat4 = 4'b1101;
   logic [1:0]  pat2 = 2'b11;

   logic [15:0] hits_o  [3];
   logic [4:0]  count_o [3];
   logic [15:0] tot_o   [3];
   logic [2:0]  tot_sat;
   logic        valid_o [3];
   logic        busy_o  [3];
   assign tot_o[2] = {13'd0, tot_sat};

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state
   int pw   [3] = '{4, 4, 2};
   int spn  [3] = '{0, 1, 0};
   int tmax [3] = '{65535, 65535, 7};
   int m_len [3], m_val [3], m_pat [3], m_ovl [3];
   int m_acc_hits [3], m_acc_cnt [3], m_hits [3], m_cnt [3], m_total [3], m_valid [3];
   int m_slot;

   always #5 clk = ~clk;

   serial_pattern_window_detector dut0 (
      .clk(clk), .rst(rst), .en(en), .in(din), .pattern(pat4), .overlap(overlap),
      .clr_total(clr_total), .hits(hits_o[0]), .count(count_o[0]), .total(tot_o[0]),
      .valid(valid_o[0]), .busy(busy_o[0]));

   serial_pattern_window_detector #(.SPAN(1'b1)) dut1 (
      .clk(clk), .rst(rst), .en(en), .in(din), .pattern(pat4), .overlap(overlap),
      .clr_total(clr_total), .hits(hits_o[1]), .count(count_o[1]), .total(tot_o[1]),
      .valid(valid_o[1]), .busy(busy_o[1]));

   serial_pattern_window_detector #(.PAT_W(2), .PAT_DEFAULT(2'b11), .TOT_W(3)) dut2 (
      .clk(clk), .rst(rst), .en(en), .in(din), .pattern(pat2), .overlap(overlap),
      .clr_total(clr_total), .hits(hits_o[2]), .count(count_o[2]), .total(tot_sat),
      .valid(valid_o[2]), .busy(busy_o[2]));

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_len[i] = 0; m_val[i] = 0; m_ovl[i] = 1;
         m_pat[i] = (i == 2) ? 3 : 13;
         m_acc_hits[i] = 0; m_acc_cnt[i] = 0; m_hits[i] = 0; m_cnt[i] = 0;
         m_total[i] = 0; m_valid[i] = 0;
      end
      m_slot = 0;
   endtask

   // one sampled edge: the last pw bits of eligible samples must equal the pattern
   task automatic model_edge(input logic e, input logic d, input logic c);
      int v;
      bit hit;
      for (int i = 0; i < 3; i++) begin
         m_valid[i] = 0;
         if (e) begin
            v   = ((m_val[i] << 1) | int'(d)) & ((1 << pw[i]) - 1);
            hit = (m_len[i] + 1 >= pw[i]) && (v == m_pat[i]);
            if (hit) begin
               m_acc_hits[i] |= (1 << m_slot);
               m_acc_cnt[i]++;
               if (m_total[i] < tmax[i]) m_total[i]++;
            end
            m_val[i] = v;
            if (hit && m_ovl[i] == 0) m_len[i] = 0;
            else if (m_len[i] < pw[i]) m_len[i]++;
            if (m_slot == 15) begin
               m_hits[i] = m_acc_hits[i]; m_cnt[i] = m_acc_cnt[i]; m_valid[i] = 1;
               m_acc_hits[i] = 0; m_acc_cnt[i] = 0;
               m_pat[i] = (i == 2) ? int'(pat2) : int'(pat4);
               m_ovl[i] = int'(overlap);
               if (spn[i] == 0) begin m_len[i] = 0; m_val[i] = 0; end
            end
         end
         if (c) m_total[i] = 0;
      end
      if (e) m_slot = (m_slot + 1) % 16;
   endtask

   task automatic step(input logic e, input logic d, input logic c);
      en = e; din = d; clr_total = c;
      @(posedge clk);
      model_edge(e, d, c);
      #1;
      if (valid_o[0])
         $display("window close: hits=%h count=%0d total=%0d (pat2 inst hits=%h count=%0d)",
                  hits_o[0], count_o[0], tot_o[0], hits_o[2], count_o[2]);
   endtask

   task automatic feed16(input logic [15:0] bits);
      for (int k = 0; k < 16; k++) step(1'b1, bits[15-k], 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1; en = 1'b0; clr_total = 1'b0;
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (hits_o[i] !== 16'h0) $display("FAIL reset_hits[%0d] got %h want 0", i, hits_o[i]); else n_pass++;
         n_checks++; if (count_o[i] !== 5'd0) $display("FAIL reset_count[%0d] got %0d want 0", i, count_o[i]); else n_pass++;
         n_checks++; if (tot_o[i] !== 16'd0) $display("FAIL reset_total[%0d] got %0d want 0", i, tot_o[i]); else n_pass++;
         n_checks++; if (valid_o[i] !== 1'b0 || busy_o[i] !== 1'b0) $display("FAIL reset_valid_busy[%0d] got %b%b want 00", i, valid_o[i], busy_o[i]); else n_pass++;
      end
   endtask

   task automatic test_overlap_window();
      overlap = 1'b1;
      for (int k = 0; k < 16; k++) begin
         if (k == 8) overlap = 1'b0;   // takes effect only for the next window
         step(1'b1, k inside {0, 1, 3, 4, 6}, 1'b0);
         if (k == 5) begin
            n_checks++; if (busy_o[0] !== 1'b1) $display("FAIL busy_mid got %b want 1", busy_o[0]); else n_pass++;
         end
      end
      n_checks++; if (hits_o[0] !== 16'h0048) $display("FAIL ovl_hits got %h want 0048", hits_o[0]); else n_pass++;
      n_checks++; if (count_o[0] !== 5'd2) $display("FAIL ovl_count got %0d want 2", count_o[0]); else n_pass++;
      n_checks++; if (tot_o[0] !== 16'd2) $display("FAIL ovl_total got %0d want 2", tot_o[0]); else n_pass++;
      n_checks++; if (valid_o[0] !== 1'b1 || busy_o[0] !== 1'b0) $display("FAIL ovl_valid_busy got %b%b want 10", valid_o[0], busy_o[0]); else n_pass++;
      n_checks++; if (hits_o[2] !== 16'(m_hits[2])) $display("FAIL ovl_hits_p2 got %h want %h", hits_o[2], m_hits[2]); else n_pass++;
      step(1'b0, 1'b0, 1'b0);
      n_checks++; if (valid_o[0] !== 1'b0) $display("FAIL valid_one_cycle got %b want 0", valid_o[0]); else n_pass++;
   endtask

   task automatic test_nonoverlap();
      for (int k = 0; k < 16; k++) begin
         if (k == 8) overlap = 1'b1;
         step(1'b1, k inside {0, 1, 3, 4, 6}, 1'b0);
      end
      n_checks++; if (hits_o[0] !== 16'h0008) $display("FAIL novl_hits got %h want 0008", hits_o[0]); else n_pass++;
      n_checks++; if (count_o[0] !== 5'd1) $display("FAIL novl_count got %0d want 1", count_o[0]); else n_pass++;
   endtask

   task automatic test_span();
      feed16(16'h0003);
      n_checks++; if (count_o[0] !== 5'd0 || count_o[1] !== 5'd0) $display("FAIL span_first_count got %0d/%0d want 0/0", count_o[0], count_o[1]); else n_pass++;
      feed16(16'h4000);
      n_checks++; if (hits_o[0] !== 16'h0000 || count_o[0] !== 5'd0) $display("FAIL span0_hits got %h/%0d want 0000/0", hits_o[0], count_o[0]); else n_pass++;
      n_checks++; if (hits_o[1] !== 16'h0002 || count_o[1] !== 5'd1) $display("FAIL span1_hits got %h/%0d want 0002/1", hits_o[1], count_o[1]); else n_pass++;
   endtask

   task automatic test_en_gap();
      int clocks = 0, pulses = 0, at_clock = -1;
      for (int k = 0; k < 16; k++) begin
         step(1'b0, 1'b1, 1'b0);
         clocks++; if (valid_o[0]) begin pulses++; at_clock = clocks; end
         step(1'b1, k inside {0, 1, 3, 4, 6}, 1'b0);
         clocks++; if (valid_o[0]) begin pulses++; at_clock = clocks; end
      end
      n_checks++; if (pulses != 1 || at_clock != 32) $display("FAIL gap_valid_timing got %0d pulses at clock %0d want 1 at 32", pulses, at_clock); else n_pass++;
      n_checks++; if (hits_o[0] !== 16'h0048 || count_o[0] !== 5'd2) $display("FAIL gap_hits got %h/%0d want 0048/2", hits_o[0], count_o[0]); else n_pass++;
   endtask

   task automatic test_saturation();
      for (int k = 0; k < 12; k++) step(1'b1, 1'b1, 1'b0);
      n_checks++; if (tot_o[2] !== 16'd7) $display("FAIL sat_total got %0d want 7", tot_o[2]); else n_pass++;
      step(1'b1, 1'b1, 1'b1);
      n_checks++; if (tot_o[2] !== 16'd0) $display("FAIL sat_clr_total got %0d want 0", tot_o[2]); else n_pass++;
      n_checks++; if (tot_o[0] !== 16'(m_total[0])) $display("FAIL clr_total_p4 got %0d want %0d", tot_o[0], m_total[0]); else n_pass++;
      while (m_slot != 0) step(1'b1, 1'b0, 1'b0);
      n_checks++; if (count_o[2] !== 5'(m_cnt[2])) $display("FAIL sat_window_count got %0d want %0d", count_o[2], m_cnt[2]); else n_pass++;
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 9; k++) step(1'b1, k inside {0, 1, 3, 4, 6}, 1'b0);
      rst = 1'b1;
      #2;
      model_reset();
      n_checks++; if (hits_o[0] !== 16'h0 || count_o[0] !== 5'd0) $display("FAIL rstmid_hits got %h/%0d want 0000/0", hits_o[0], count_o[0]); else n_pass++;
      n_checks++; if (tot_o[0] !== 16'd0 || busy_o[0] !== 1'b0 || valid_o[0] !== 1'b0) $display("FAIL rstmid_state got total=%0d busy=%b valid=%b want 0/0/0", tot_o[0], busy_o[0], valid_o[0]); else n_pass++;
      @(posedge clk); #1;
      rst = 1'b0;
      n_checks++; if (valid_o[0] !== 1'b0) $display("FAIL rstmid_no_valid got %b want 0", valid_o[0]); else n_pass++;
      feed16(16'h000D);   // completes 1101 on the closing slot
      n_checks++; if (hits_o[0] !== 16'h8000 || count_o[0] !== 5'd1) $display("FAIL close_match got %h/%0d want 8000/1", hits_o[0], count_o[0]); else n_pass++;
      n_checks++; if (tot_o[0] !== 16'd1) $display("FAIL rstmid_total got %0d want 1", tot_o[0]); else n_pass++;
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 39) == 0) pat4 = 4'($urandom);
         if ($urandom_range(0, 39) == 0) pat2 = 2'($urandom);
         if ($urandom_range(0, 29) == 0) overlap = 1'($urandom);
         step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 40) == 0);
         for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (hits_o[i] !== 16'(m_hits[i]) || count_o[i] !== 5'(m_cnt[i]) ||
                tot_o[i] !== 16'(m_total[i]) || valid_o[i] !== 1'(m_valid[i]) ||
                busy_o[i] !== (m_slot != 0))
               $display("FAIL rand[%0d] inst%0d got h=%h c=%0d t=%0d v=%b b=%b want h=%h c=%0d t=%0d v=%0d b=%0d",
                        n, i, hits_o[i], count_o[i], tot_o[i], valid_o[i], busy_o[i],
                        m_hits[i], m_cnt[i], m_total[i], m_valid[i], m_slot != 0);
            else n_pass++;
         end
      end
   endtask

   initial begin
      #2;
      test_reset();
      test_overlap_window();
      test_nonoverlap();
      test_span();
      test_en_gap();
      test_saturation();
      test_reset_mid();
      pat4 = 4'b1011;
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/serial_pattern_window_detector.md
# serial_pattern_window_detector

Parametrised serial pattern detector for a 1-bit input stream. It matches a configurable PAT_W-bit pattern, MSB first, in fixed windows of 2^WIN_LOG2 enabled cycles. At each window close it publishes a per-slot hit bitmap and a hit count. It also keeps a saturating running total and offers overlapping and non-overlapping match modes. It sits directly behind the serial sampling front end and feeds the display/readout logic that consumes per-window snapshots.

## Interface
- PAT_W, 4, pattern length in bits (2..16)
- PAT_DEFAULT, 4'b1101, pattern loaded at reset
- WIN_LOG2, 4, window length = 2^WIN_LOG2 enabled cycles (2..8)
- TOT_W, 16, running-total width
- SPAN, 0, 1 = match history carries across window boundaries; 0 = history cleared at boundary
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  sample enable; when low nothing advances
- in  in  1  serial data bit, sampled when en=1
- pattern  in  PAT_W  pattern for next window (quasi-static)
- overlap  in  1  1 = overlapping matches, 0 = non-overlapping (quasi-static)
- clr_total  in  1  synchronous clear of total
- hits  out  2^WIN_LOG2  bitmap of last completed window, bit k = match completed at slot k
- count  out  WIN_LOG2+1  number of matches in last completed window
- total  out  TOT_W  saturating sum of all matches since reset/clear
- valid  out  1  one-cycle pulse: hits/count just updated
- busy  out  1  high while slot counter != 0 (window in progress)

## Operation
- Reset (async): hits=0, count=0, total=0, valid=0, busy=0, slot=0, history=0, fill=0, active pattern=PAT_DEFAULT, active overlap=1, accumulators=0.
- slot counter (WIN_LOG2 bits) advances by 1 on every en=1 edge and wraps from 2^WIN_LOG2-1 to 0.
- history: shift register of PAT_W-1 previous bits.
- fill: saturating count of valid history bits, 0..PAT_W.
- Match at a sampled edge: {history, in} == active pattern and fill+1 >= PAT_W.
- On a match:
  - set acc_hits[slot];
  - acc_count += 1;
  - total += 1, saturating at 2^TOT_W-1.
- After a match:
  - overlap=1: history shifts normally.
  - overlap=0: fill is forced to 0, so the next match needs PAT_W fresh bits.
- Window close = en=1 edge with slot = 2^WIN_LOG2-1. On that edge:
  - hits <= acc_hits including the current slot's match.
  - count <= acc_count plus the current match.
  - valid <= 1.
  - Accumulators clear.
  - Active pattern and overlap reload from the ports.
  - If SPAN=0, history and fill clear.
- Any other edge: valid <= 0.
- en=0: no shift, no slot advance, no match. valid still falls.
- clr_total=1: total <= 0 on that edge. It takes priority over a same-edge increment.
- count width WIN_LOG2+1 holds the maximum 2^WIN_LOG2 hits (PAT_W=2, overlap, all-matching stream); no overflow is possible.
- Changing pattern/overlap mid-window has no effect until the next window starts.

## Timing
- Match-to-total latency: total reflects a match from the edge on which the completing bit is sampled.
- Window latency: hits/count/valid update on the closing edge. valid is high exactly the following cycle.
- busy is combinational from slot: low during slot 0, including the cycle after close.
- Reset asserted mid-window:
  - all state returns to reset values immediately;
  - no valid pulse;
  - the partial window is discarded;
  - the first window after release starts at slot 0.
- Simultaneous close + match at slot 2^WIN_LOG2-1: the match is included in the closing snapshot, not the next window.
- Simultaneous total saturation + clr_total: result 0.

## Test plan
- PAT 1101, WIN_LOG2=4, overlap=1, bits 1,1,0,1,1,0,1 at slots 0..6, zeros after -> at close hits=16'h0048, count=2, total=2, valid high one cycle.
- Same stream, overlap=0 (set before the window starts) -> hits=16'h0008, count=1.
- SPAN=0, bits 1,1 at slots 14,15 then 0,1 at slots 0,1 -> no match in either window. With SPAN=1 -> next window hits bit 1 set, count=1.
- en toggled low every other cycle during the first stream -> identical hits/count. valid occurs after 16 enabled edges, not 16 clocks.
- TOT_W=3, stream of 10 overlapping PAT 11 matches -> total sticks at 7. clr_total on a match edge -> total=0.
- rst pulsed at slot 9 after 2 matches -> hits=0, count=0, total=0, busy=0, no valid. The next close reports only post-reset matches.
